// File: rtl/bitbakery_session_if.sv
// Bundle of the session controller's request, per-game and result signals.
// The controller takes the slave view; whoever drives the requests and game buses takes master.
interface bitbakery_session_if #(
  parameter int unsigned NUM_GAMES = 3,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned LEDS_W    = 3,
  parameter int unsigned EST_W     = 4,
  parameter int unsigned JOG_W     = 7,
  parameter int unsigned PONT_W    = 3,
  parameter int unsigned ROUNDS    = 4,
  parameter int unsigned TOT_W     = 6
) ();
  localparam int unsigned RND_W = $clog2(ROUNDS + 1);

  // Requests and per-game buses (game i at [i*W +: W])
  logic                        iniciar;
  logic                        dificuldade;
  logic [SEL_W-1:0]            minigame;
  logic [NUM_GAMES-1:0]        game_pronto;
  logic [NUM_GAMES*LEDS_W-1:0] game_leds;
  logic [NUM_GAMES*EST_W-1:0]  game_estado;
  logic [NUM_GAMES*JOG_W-1:0]  game_jogada;
  logic [NUM_GAMES*PONT_W-1:0] game_pontuacao;

  // Controller results
  logic                        jogar;
  logic                        dificuldade_out;
  logic [SEL_W-1:0]            minigame_out;
  logic [LEDS_W-1:0]           leds_out;
  logic [EST_W-1:0]            estado_out;
  logic [JOG_W-1:0]            jogada_out;
  logic [PONT_W-1:0]           pontuacao_out;
  logic [TOT_W-1:0]            total_out;
  logic [TOT_W-1:0]            recorde_out;
  logic [RND_W-1:0]            rodada_out;
  logic                        sessao_fim;
  logic                        timeout_flag;

  modport master (
    output iniciar, dificuldade, minigame, game_pronto, game_leds, game_estado, game_jogada,
           game_pontuacao,
    input  jogar, dificuldade_out, minigame_out, leds_out, estado_out, jogada_out,
           pontuacao_out, total_out, recorde_out, rodada_out, sessao_fim, timeout_flag
  );

  modport slave (
    input  iniciar, dificuldade, minigame, game_pronto, game_leds, game_estado, game_jogada,
           game_pontuacao,
    output jogar, dificuldade_out, minigame_out, leds_out, estado_out, jogada_out,
           pontuacao_out, total_out, recorde_out, rodada_out, sessao_fim, timeout_flag
  );
endinterface

// File: rtl/bitbakery_session.sv
// Session controller for a set of minigames: selects a game, starts it, scores each round,
// accumulates a saturating session total and keeps the best session total since reset.
module bitbakery_session #(
  parameter int unsigned NUM_GAMES = 3,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned LEDS_W    = 3,
  parameter int unsigned EST_W     = 4,
  parameter int unsigned JOG_W     = 7,
  parameter int unsigned PONT_W    = 3,
  parameter int unsigned ROUNDS    = 4,
  parameter int unsigned TOT_W     = 6,
  parameter int unsigned TIMEOUT   = 0
) (
  input logic                clock,
  input logic                reset,
  bitbakery_session_if.slave bus
);
  localparam int unsigned RND_W = $clog2(ROUNDS + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SUM_W = ((TOT_W > PONT_W) ? TOT_W : PONT_W) + 1;

  typedef enum logic [2:0] {
    StInicial    = 3'd0,
    StPreparacao = 3'd1,
    StExecucao   = 3'd2,
    StPontua     = 3'd3,
    StFimRodada  = 3'd4,
    StFimSessao  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               iniciar_q;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [TOT_W-1:0]   total_q, total_d;
  logic [TOT_W-1:0]   recorde_q, recorde_d;
  logic [RND_W-1:0]   rodada_q, rodada_d;
  logic               tflag_q, tflag_d;
  logic               jogar_q, jogar_d;
  logic               dif_q, dif_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  logic               start_ev;
  logic               timeout_hit;
  logic               sel_pronto;
  logic [LEDS_W-1:0]  sel_leds;
  logic [EST_W-1:0]   sel_est;
  logic [JOG_W-1:0]   sel_jog;
  logic [PONT_W-1:0]  sel_pont;
  logic [PONT_W-1:0]  add;
  logic [SUM_W-1:0]   sum;
  logic [TOT_W-1:0]   total_sat;

  assign start_ev    = bus.iniciar & ~iniciar_q;
  assign timeout_hit = (TIMEOUT > 0) && (32'(timer_q) == TIMEOUT - 1);

  // Slice the latched game out of the packed buses; out-of-range selection reads as zero
  always_comb begin
    sel_pronto = 1'b0;
    sel_leds   = '0;
    sel_est    = '0;
    sel_jog    = '0;
    sel_pont   = '0;
    for (int unsigned i = 0; i < NUM_GAMES; i++) begin
      if (32'(sel_q) == i) begin
        sel_pronto = bus.game_pronto[i];
        sel_leds   = bus.game_leds[i*LEDS_W +: LEDS_W];
        sel_est    = bus.game_estado[i*EST_W +: EST_W];
        sel_jog    = bus.game_jogada[i*JOG_W +: JOG_W];
        sel_pont   = bus.game_pontuacao[i*PONT_W +: PONT_W];
      end
    end
  end

  // Round score (nothing on timeout) added to the total, clamped at all ones
  always_comb begin
    add       = tflag_q ? '0 : sel_pont;
    sum       = SUM_W'(total_q) + SUM_W'(add);
    total_sat = (sum > SUM_W'({TOT_W{1'b1}})) ? '1 : sum[TOT_W-1:0];
  end

  // Next-state and datapath updates of the session FSM
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    total_d   = total_q;
    recorde_d = recorde_q;
    rodada_d  = rodada_q;
    tflag_d   = tflag_q;
    dif_d     = dif_q;
    sel_d     = sel_q;
    case (state_q)
      StInicial: begin
        if (start_ev) begin
          state_d  = StPreparacao;
          total_d  = '0;
          rodada_d = '0;
          tflag_d  = 1'b0;
        end
      end
      StPreparacao: begin
        sel_d   = bus.minigame;
        dif_d   = bus.dificuldade;
        timer_d = '0;
        if (32'(bus.minigame) < NUM_GAMES) state_d = StExecucao;
      end
      StExecucao: begin
        timer_d = timer_q + 1'b1;
        // A done game beats a simultaneous timeout
        if (sel_pronto) begin
          state_d = StPontua;
          tflag_d = 1'b0;
        end else if (timeout_hit) begin
          state_d = StPontua;
          tflag_d = 1'b1;
        end
      end
      StPontua: begin
        total_d  = total_sat;
        rodada_d = rodada_q + 1'b1;
        if (32'(rodada_q) + 1 == ROUNDS) begin
          state_d = StFimSessao;
          if (total_sat > recorde_q) recorde_d = total_sat;
        end else begin
          state_d = StFimRodada;
        end
      end
      StFimRodada: begin
        if (start_ev) begin
          state_d = StPreparacao;
          tflag_d = 1'b0;
        end
      end
      StFimSessao: begin
        if (start_ev) begin
          state_d  = StPreparacao;
          total_d  = '0;
          rodada_d = '0;
          tflag_d  = 1'b0;
        end
      end
      default: state_d = StInicial;
    endcase
    jogar_d = (state_d == StExecucao) && (state_q != StExecucao);
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StInicial;
      iniciar_q <= 1'b0;
      timer_q   <= '0;
      total_q   <= '0;
      recorde_q <= '0;
      rodada_q  <= '0;
      tflag_q   <= 1'b0;
      jogar_q   <= 1'b0;
      dif_q     <= 1'b0;
      sel_q     <= '1;
    end else begin
      state_q   <= state_d;
      iniciar_q <= bus.iniciar;
      timer_q   <= timer_d;
      total_q   <= total_d;
      recorde_q <= recorde_d;
      rodada_q  <= rodada_d;
      tflag_q   <= tflag_d;
      jogar_q   <= jogar_d;
      dif_q     <= dif_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.jogar           = jogar_q;
  assign bus.dificuldade_out = dif_q;
  assign bus.minigame_out    = sel_q;
  assign bus.leds_out        = sel_leds;
  assign bus.jogada_out      = sel_jog;
  assign bus.pontuacao_out   = sel_pont;
  assign bus.estado_out      = (state_q == StExecucao) ? sel_est : EST_W'(state_q);
  assign bus.total_out       = total_q;
  assign bus.recorde_out     = recorde_q;
  assign bus.rodada_out      = rodada_q;
  assign bus.sessao_fim      = (state_q == StFimSessao);
  assign bus.timeout_flag    = tflag_q;

endmodule

// File: tb/tb_bitbakery_session.sv
// Directed bench for bitbakery_session: two instances (6-bit and 4-bit totals, timeout 20)
// share one stimulus; a small model pushes expected round results that are popped at round end.
module tb_bitbakery_session;
  localparam int unsigned NG = 3;
  localparam int unsigned RN = 4;
  localparam int unsigned TO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        dificuldade = 1'b0;
  logic [1:0]  minigame = 2'd0;
  logic [2:0]  pronto = 3'b000;
  logic [8:0]  leds_bus = 9'd0;
  logic [11:0] est_bus = 12'd0;
  logic [20:0] jog_bus = 21'd0;
  logic [8:0]  pont_bus = 9'd0;

  bitbakery_session_if #(.NUM_GAMES(NG), .SEL_W(2), .LEDS_W(3), .EST_W(4), .JOG_W(7),
                         .PONT_W(3), .ROUNDS(RN), .TOT_W(6)) ifa ();
  bitbakery_session_if #(.NUM_GAMES(NG), .SEL_W(2), .LEDS_W(3), .EST_W(4), .JOG_W(7),
                         .PONT_W(3), .ROUNDS(RN), .TOT_W(4)) ifb ();

  assign ifa.iniciar        = iniciar;
  assign ifa.dificuldade    = dificuldade;
  assign ifa.minigame       = minigame;
  assign ifa.game_pronto    = pronto;
  assign ifa.game_leds      = leds_bus;
  assign ifa.game_estado    = est_bus;
  assign ifa.game_jogada    = jog_bus;
  assign ifa.game_pontuacao = pont_bus;
  assign ifb.iniciar        = iniciar;
  assign ifb.dificuldade    = dificuldade;
  assign ifb.minigame       = minigame;
  assign ifb.game_pronto    = pronto;
  assign ifb.game_leds      = leds_bus;
  assign ifb.game_estado    = est_bus;
  assign ifb.game_jogada    = jog_bus;
  assign ifb.game_pontuacao = pont_bus;

  bitbakery_session #(.NUM_GAMES(NG), .SEL_W(2), .LEDS_W(3), .EST_W(4), .JOG_W(7), .PONT_W(3),
                      .ROUNDS(RN), .TOT_W(6), .TIMEOUT(TO)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  bitbakery_session #(.NUM_GAMES(NG), .SEL_W(2), .LEDS_W(3), .EST_W(4), .JOG_W(7), .PONT_W(3),
                      .ROUNDS(RN), .TOT_W(4), .TIMEOUT(TO)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int jog_cnt = 0;

  // Count jogar cycles; read from the main thread only at falling edges
  always @(posedge clock) jog_cnt <= jog_cnt + ((ifa.jogar === 1'b1) ? 1 : 0);

  typedef struct {
    int tot_a;
    int tot_b;
    int rod;
    int tfl;
    int fim;
    int st;
    int rec_a;
    int rec_b;
  } exp_t;

  exp_t sb[$];

  int m_tot_a = 0, m_tot_b = 0, m_rod = 0, m_rec_a = 0, m_rec_b = 0;
  bit m_end = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode 0: normal round; 1: invalid selection held first; 2: iniciar held, no pronto (timeout)
  task automatic play(input int g, input int score, input int delay, input int mode,
                      input logic dif);
    int   j0, n, lim, add, pre_a, pre_rod;
    bit   got;
    exp_t e;
    exp_t r;
    @(negedge clock);
    if (m_end) begin
      m_tot_a = 0; m_tot_b = 0; m_rod = 0; m_end = 1'b0;
    end
    pre_a   = m_tot_a;
    pre_rod = m_rod;
    add     = (mode == 2) ? 0 : score;
    m_tot_a = (m_tot_a + add > 63) ? 63 : m_tot_a + add;
    m_tot_b = (m_tot_b + add > 15) ? 15 : m_tot_b + add;
    m_rod++;
    if (m_rod == RN) begin
      m_end = 1'b1;
      if (m_tot_a > m_rec_a) m_rec_a = m_tot_a;
      if (m_tot_b > m_rec_b) m_rec_b = m_tot_b;
    end
    e.tot_a = m_tot_a; e.tot_b = m_tot_b; e.rod = m_rod; e.tfl = (mode == 2) ? 1 : 0;
    e.fim = m_end ? 1 : 0; e.st = m_end ? 5 : 4; e.rec_a = m_rec_a; e.rec_b = m_rec_b;
    sb.push_back(e);

    pont_bus = {3'd2, 3'd6, 3'd1};
    pont_bus[g*3 +: 3] = 3'(score);
    dificuldade = dif;
    minigame = (mode == 1) ? 2'd3 : 2'(g);
    j0 = jog_cnt;
    iniciar = 1'b1;
    n = 1;
    @(negedge clock); n++;
    if (mode != 2) iniciar = 1'b0;
    if (mode == 1) begin
      repeat (4) begin
        @(negedge clock); n++;
        chk("hold_state", ifa.estado_out, 1);
        chk("hold_jogar", ifa.jogar, 0);
      end
      chk("hold_sel", ifa.minigame_out, 3);
      chk("hold_leds", ifa.leds_out, 0);
      minigame = 2'(g);
      @(negedge clock); n++;
      chk("release_jogar", ifa.jogar, 1);
    end else begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clock); n++;
        got = (ifa.jogar === 1'b1);
      end
      chk("jogar_seen", got, 1);
    end

    lim = (mode == 2) ? TO : delay;
    for (int k = 1; k <= lim; k++) begin
      if (k > 1) begin @(negedge clock); n++; end
      if (k == 1) begin
        chk("start_total", ifa.total_out, pre_a);
        chk("start_rodada", ifa.rodada_out, pre_rod);
        chk("start_tflag", ifa.timeout_flag, 0);
        chk("start_fim", ifa.sessao_fim, 0);
      end
      if (k == 2) begin
        chk("sel_game", ifa.minigame_out, g);
        chk("sel_dif", ifa.dificuldade_out, dif);
        chk("sel_leds", ifa.leds_out, leds_bus[g*3 +: 3]);
        chk("sel_estado", ifa.estado_out, est_bus[g*4 +: 4]);
        chk("sel_jogada", ifa.jogada_out, jog_bus[g*7 +: 7]);
        chk("sel_pont", ifa.pontuacao_out, score);
        chk("one_jogar", ifa.jogar, 0);
      end
      if (k == 3) begin
        minigame = 2'((g + 1) % 3);
        dificuldade = ~dif;
      end
      if (k == 4) begin
        chk("frozen_sel", ifa.minigame_out, g);
        chk("frozen_dif", ifa.dificuldade_out, dif);
      end
      pronto = (mode != 2 && k == delay) ? 3'b111 : (3'b111 & ~(3'b001 << g));
    end

    got = 1'b0;
    for (int t = 0; t < 6 && !got; t++) begin
      @(negedge clock); n++;
      pronto = 3'b000;
      got = (ifa.estado_out == 4'd4 || ifa.estado_out == 4'd5);
    end
    chk("round_end", got, 1);
    r = sb.pop_front();
    chk("total_a", ifa.total_out, r.tot_a);
    chk("total_b", ifb.total_out, r.tot_b);
    chk("rodada", ifa.rodada_out, r.rod);
    chk("tflag", ifa.timeout_flag, r.tfl);
    chk("sessao_fim", ifa.sessao_fim, r.fim);
    chk("end_state", ifa.estado_out, r.st);
    chk("recorde_a", ifa.recorde_out, r.rec_a);
    chk("recorde_b", ifb.recorde_out, r.rec_b);
    chk("jogar_pulses", jog_cnt - j0, 1);
    if (mode == 2) begin
      while (n < 50) begin @(negedge clock); n++; end
      chk("held_state", ifa.estado_out, 4);
      chk("held_rodada", ifa.rodada_out, r.rod);
      chk("held_jogar", jog_cnt - j0, 1);
      iniciar = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  j0;
    bit  got;
    leds_bus = {3'd4, 3'd2, 3'd1};
    est_bus  = {4'hC, 4'hB, 4'hA};
    jog_bus  = {7'h33, 7'h22, 7'h11};
    pont_bus = {3'd2, 3'd6, 3'd1};
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_jogar", ifa.jogar, 0);
    chk("rst_total", ifa.total_out, 0);
    chk("rst_recorde", ifa.recorde_out, 0);
    chk("rst_rodada", ifa.rodada_out, 0);
    chk("rst_fim", ifa.sessao_fim, 0);
    chk("rst_tflag", ifa.timeout_flag, 0);
    chk("rst_sel", ifa.minigame_out, 3);
    chk("rst_dif", ifa.dificuldade_out, 0);
    chk("rst_estado", ifa.estado_out, 0);
    chk("rst_leds", ifa.leds_out, 0);
    chk("rst_pont", ifa.pontuacao_out, 0);
    chk("rst_total_b", ifb.total_out, 0);
    reset = 1'b0;

    // Session 1: includes pronto coinciding with the timeout cycle and pronto on the jogar cycle
    play(1, 5, 10, 0, 1'b1);
    play(2, 7, 3, 0, 1'b0);
    play(0, 7, 20, 0, 1'b1);
    play(1, 7, 1, 0, 1'b0);
    // Session 2: 4 x 7 = 28 beats the record; 4-bit instance saturates at 15
    play(0, 7, 5, 0, 1'b0);
    play(1, 7, 4, 0, 1'b1);
    play(2, 7, 6, 0, 1'b0);
    play(0, 7, 2, 0, 1'b1);
    // Session 3: 4 x 3 = 12, record kept; first round starts with an invalid selection
    play(0, 3, 4, 1, 1'b1);
    play(2, 3, 6, 0, 1'b0);
    play(1, 3, 2, 0, 1'b1);
    play(0, 3, 5, 0, 1'b0);
    // Session 4: timed-out round with iniciar held, then a scoring round
    play(2, 6, 0, 2, 1'b0);
    play(2, 6, 3, 0, 1'b1);

    // Reset in the middle of a round
    @(negedge clock);
    minigame = 2'd1;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clock);
      got = (ifa.jogar === 1'b1);
    end
    chk("mid_jogar_seen", got, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_estado", ifa.estado_out, 0);
    chk("mid_rst_total", ifa.total_out, 0);
    chk("mid_rst_recorde", ifa.recorde_out, 0);
    chk("mid_rst_rodada", ifa.rodada_out, 0);
    chk("mid_rst_jogar", ifa.jogar, 0);
    chk("mid_rst_sel", ifa.minigame_out, 3);
    chk("mid_rst_leds", ifa.leds_out, 0);
    chk("mid_rst_jogada", ifa.jogada_out, 0);
    chk("mid_rst_total_b", ifb.total_out, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pronto = 3'b111;
    j0 = jog_cnt;
    repeat (4) @(negedge clock);
    chk("post_rst_estado", ifa.estado_out, 0);
    chk("post_rst_jogar", jog_cnt - j0, 0);
    chk("post_rst_total", ifa.total_out, 0);
    chk("post_rst_recorde_b", ifb.recorde_out, 0);
    pronto = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
